// File: rtl/mtr_pwm_drv.sv
// Signed wheel-speed to H-bridge PWM: 2048-clock period, per-side reversal blanking, over-speed fault latch.
// Outputs are registered, one clock behind the counter value they decode.

module mtr_pwm_side (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap,
    input  logic [10:0] cnt,
    input  logic [11:0] spd,
    input  logic        en_nxt,
    output logic        fwd,
    output logic        rev
);
    typedef enum logic {DRIVE = 1'b0, BLANK = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] mag;
    logic [10:0] mag_nxt;
    logic        dir;
    logic        dir_nxt;
    logic [11:0] spd_abs;
    logic [10:0] new_mag;
    logic        new_nz;
    logic        new_dir;
    logic        drv;

    always_comb begin
        spd_abs = spd[11] ? 12'(-spd) : spd;
        // Only -2048 leaves bit 11 set after negation; clamp it to the 11-bit maximum.
        new_mag = spd_abs[11] ? 11'h7ff : spd_abs[10:0];
        new_nz  = |new_mag;
        new_dir = new_nz ? spd[11] : dir;

        state_nxt = state;
        mag_nxt   = mag;
        dir_nxt   = dir;
        if (cap) begin
            mag_nxt = new_mag;
            dir_nxt = new_dir;
            if (!en_nxt || state == BLANK) begin
                state_nxt = DRIVE;
            end else if (new_nz && (new_dir != dir)) begin
                state_nxt = BLANK;
            end
        end else if (!en_nxt) begin
            state_nxt = DRIVE;
        end

        drv = en_nxt && (state_nxt == DRIVE) && (cnt < mag_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DRIVE;
            mag   <= 11'd0;
            dir   <= 1'b0;
            fwd   <= 1'b0;
            rev   <= 1'b0;
        end else begin
            state <= state_nxt;
            mag   <= mag_nxt;
            dir   <= dir_nxt;
            fwd   <= drv & ~dir_nxt;
            rev   <= drv & dir_nxt;
        end
    end
endmodule

module mtr_pwm_drv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        too_fast,
    input  logic        clr_flt,
    output logic        lft_fwd,
    output logic        lft_rev,
    output logic        rght_fwd,
    output logic        rght_rev,
    output logic        flt,
    output logic        prd_strt
);
    logic [10:0] cnt;
    logic        cnt_zero;
    logic        flt_nxt;
    logic        pwm_en;
    logic        en_nxt;

    // pwm_en keeps the outputs off for the remainder of a period after a fault clears.
    always_comb begin
        cnt_zero = (cnt == 11'd0);
        flt_nxt  = too_fast | (flt & ~clr_flt);
        en_nxt   = ~flt_nxt & (pwm_en | cnt_zero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 11'd0;
            flt      <= 1'b0;
            pwm_en   <= 1'b0;
            prd_strt <= 1'b0;
        end else begin
            cnt      <= cnt + 11'd1;
            flt      <= flt_nxt;
            pwm_en   <= en_nxt;
            prd_strt <= cnt_zero;
        end
    end

    mtr_pwm_side u_lft (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap    (cnt_zero),
        .cnt    (cnt),
        .spd    (lft_spd),
        .en_nxt (en_nxt),
        .fwd    (lft_fwd),
        .rev    (lft_rev)
    );

    mtr_pwm_side u_rght (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap    (cnt_zero),
        .cnt    (cnt),
        .spd    (rght_spd),
        .en_nxt (en_nxt),
        .fwd    (rght_fwd),
        .rev    (rght_rev)
    );
endmodule
